// File: rtl/mem_access_ctrl.sv
// Data-memory access controller: sequences loads and stores over a req/ack bus and freezes the pipeline.
// Requests are issued from registers. Completion is ack-driven, and an ACCESS that runs too long is aborted by a timeout.
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EX_MEM_MemRead,
  input  logic        EX_MEM_MemWrite,
  input  logic [31:0] EX_MEM_ALUOut,
  input  logic [31:0] EX_MEM_WriteData,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] MEM_Read_Data,
  output logic        stall,
  output logic        mem_wb_bubble,
  output logic        bus_error,
  output logic [31:0] stall_count
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          memop;

  assign memop         = EX_MEM_MemRead | EX_MEM_MemWrite;
  assign stall         = !rst && ((state == IDLE && memop) || state == ACCESS);
  assign mem_wb_bubble = stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      MEM_Read_Data <= '0;
      bus_error     <= 1'b0;
      stall_count   <= '0;
    end else begin
      bus_error <= 1'b0;
      if (stall && stall_count != 32'hFFFF_FFFF)
        stall_count <= stall_count + 32'd1;

      case (state)
        IDLE: begin
          if (memop) begin
            // A load/store conflict resolves to a write.
            mem_req   <= 1'b1;
            mem_we    <= EX_MEM_MemWrite;
            mem_addr  <= EX_MEM_ALUOut;
            mem_wdata <= EX_MEM_WriteData;
            cnt       <= '0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            MEM_Read_Data <= mem_rdata;
            mem_req       <= 1'b0;
            state         <= DONE;
          end else if (cnt == CNT_LAST) begin
            MEM_Read_Data <= 32'hDEAD_BEEF;
            mem_req       <= 1'b0;
            bus_error     <= 1'b1;
            state         <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Data-memory access controller for the five-stage pipeline. It sits between the EX/MEM pipeline register and a variable-latency data memory with a req/ack handshake. It sequences each load or store as a bus transaction and freezes the upstream pipeline registers until the transaction completes. It also feeds the MEM/WB register with the read data and a bubble control, so stalled cycles never write back.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 255: maximum ACCESS cycles without ack before aborting; legal range ≥1. Counter width is clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- EX_MEM_MemRead  in  1  instruction in EX/MEM is a load.
- EX_MEM_MemWrite  in  1  instruction in EX/MEM is a store.
- EX_MEM_ALUOut  in  32  byte address of the access.
- EX_MEM_WriteData  in  32  store data.
- mem_req  out  1  registered bus request.
- mem_we  out  1  registered write enable, valid while mem_req=1.
- mem_addr  out  32  registered address, valid while mem_req=1.
- mem_wdata  out  32  registered store data, valid while mem_req=1.
- mem_ack  in  1  memory completion; sampled only in ACCESS.
- mem_rdata  in  32  read data, valid in the cycle mem_ack=1.
- MEM_Read_Data  out  32  registered load result to the MEM/WB register.
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM (combinational).
- mem_wb_bubble  out  1  force MEM/WB RegWrite=0 and MemtoReg=0 at its inputs. Equal to stall.
- bus_error  out  1  one-cycle pulse on timeout abort.
- stall_count  out  32  saturating count of stalled cycles.

## Operation
- Define memop = EX_MEM_MemRead | EX_MEM_MemWrite.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If memop=1: latch address, store data and write enable (we = EX_MEM_MemWrite), set mem_req=1, clear the timeout counter, and go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable.
  - If mem_ack=1: capture mem_rdata into MEM_Read_Data, drop mem_req, and go to DONE.
  - Otherwise, if the counter equals TIMEOUT_CYCLES-1: drop mem_req, load MEM_Read_Data=32'hDEADBEEF, set bus_error for the DONE cycle, and go to DONE.
  - Otherwise increment the counter.
- DONE:
  - stall=0, so the pipeline advances at the end of this cycle with MEM_Read_Data valid.
  - Always go to IDLE; the same instruction is never re-issued.
- stall = !rst & ((IDLE & memop) | ACCESS).
- For stores, MEM_Read_Data still captures mem_rdata; it is don't-care downstream because MemtoReg does not select it.
- MemRead and MemWrite both set (illegal): treated as a write (mem_we=1).
- mem_ack in IDLE or DONE: ignored, no state change.
- stall_count increments in each cycle where stall=1 and saturates at 32'hFFFFFFFF.

## Timing
- Reset values: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, MEM_Read_Data=0, counter=0, bus_error=0, stall_count=0. While rst=1: stall=0 and mem_wb_bubble=0.
- Reset in ACCESS: mem_req is 0 after the reset edge; no DONE and no bus_error.
- Minimum access, with ack in the first ACCESS cycle:
  - c0: IDLE, stall=1.
  - c1: ACCESS, mem_req=1, mem_ack=1, stall=1.
  - c2: DONE, data valid, stall=0.
  - The instruction leaves EX/MEM at the end of c2. This costs 2 stall cycles per memory op.
- General case: ack in the k-th ACCESS cycle costs k+1 stall cycles.
- Timeout: mem_req stays high for exactly TIMEOUT_CYCLES cycles; bus_error is high only in the following DONE cycle.
- Back-to-back memops: DONE → IDLE → ACCESS. A second memop entering EX/MEM after DONE is detected in IDLE that cycle.
- Non-memory instructions never stall and never touch the bus.

## Test plan
- Reset then idle: rst high 2 cycles, memop=0 for 10 cycles → all outputs 0, stall_count=0.
- Load, ack after 3 cycles: MemRead=1, addr=32'h0000_0040, mem_rdata=32'h1234_5678 → mem_req high 3 cycles with addr 0x40 and we=0; stall high 4 cycles; DONE shows MEM_Read_Data=0x12345678 with stall=0; stall_count=4.
- Store, ack immediately: MemWrite=1, addr=32'h80, wdata=32'hCAFE_F00D → mem_we=1, mem_wdata=0xCAFEF00D for 1 cycle; stall=2 cycles; bus_error=0.
- Timeout with TIMEOUT_CYCLES=4, no ack → mem_req high exactly 4 cycles; DONE with MEM_Read_Data=0xDEADBEEF and a 1-cycle bus_error.
- Back-to-back loads at 0x10 then 0x14, each acked in the first ACCESS cycle → two separate transactions; second mem_req begins 2 cycles after the first DONE (IDLE then ACCESS); no duplicate request for 0x10.
- rst asserted in the 2nd ACCESS cycle of a load, plus a spurious mem_ack while IDLE → after the reset edge mem_req=0, state IDLE, no bus_error; the stray ack causes no state change.
